sequence_player: RTL and testbench



---
 rtl/simon_pkg.sv | 10 +
 rtl/simon_lfsr.sv | 14 +
 rtl/sequence_player.sv | 103 ++++++++++
 tb/tb_sequence_player.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared direction encodings, default move count and player states
package simon_pkg;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;
  localparam logic [1:0] DIR_LEFT = 2'd3;
  localparam int DEF_NUM_MOVES = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef enum logic [1:0] {IDLE, SHOW, GAP, FINISH} state_t;
endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: 16-bit Fibonacci LFSR, taps 16,14,13,11, reloads SEED on reset
module simon_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);
  // shift left, feedback from taps 16,14,13,11 enters at bit 0
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= SEED;
    else if (en) q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays a latched move sequence MSB-first on the direction LEDs; SEQ_LFSR_EN sources the sequence from an LFSR
module sequence_player
  import simon_pkg::*;
#(
  parameter int NUM_MOVES = DEF_NUM_MOVES,
  parameter int ON_CYCLES = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int CNT_W = 25
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [2*NUM_MOVES-1:0]       sequence_in,
  output logic [2*NUM_MOVES-1:0]       sequence_out,
  output logic                         busy,
  output logic                         led_valid,
  output logic [1:0]                   led_dir,
  output logic [3:0]                   led_onehot,
  output logic [$clog2(NUM_MOVES)-1:0] move_idx,
  output logic                         done
);
  localparam int IW = $clog2(NUM_MOVES);
  localparam int SW = 2 * NUM_MOVES;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IW-1:0] idx_n;
  logic [SW-1:0] seq_n, load, shifted;
  logic last_on, last_off, last_move;
`ifdef SEQ_LFSR_EN
  logic [15:0] lfsr;
  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock(clock),
    .reset(reset),
    .en(1'b1),
    .q(lfsr)
  );
  assign load = lfsr[SW-1:0];
`else
  assign load = sequence_in;
`endif
  assign last_on = cnt == CNT_W'(ON_CYCLES - 1);
  assign last_off = cnt == CNT_W'(OFF_CYCLES - 1);
  assign last_move = move_idx == IW'(NUM_MOVES - 1);
  // next state: dwell counter restarts on every state change, abort drops to idle
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = move_idx;
    seq_n = sequence_out;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (start) begin
          state_n = SHOW;
          seq_n = load;
        end
      end
      SHOW: if (last_on) begin
        state_n = GAP;
        cnt_n = '0;
      end
      GAP: if (last_off) begin
        state_n = last_move ? FINISH : SHOW;
        cnt_n = '0;
        idx_n = last_move ? move_idx : move_idx + 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
        idx_n = '0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n = '0;
      idx_n = '0;
    end
  end
  // state, counter, move index and latched sequence registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      move_idx <= '0;
      sequence_out <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      move_idx <= idx_n;
      sequence_out <= seq_n;
    end
  // outputs decode straight from state so reset clears them immediately
  always_comb begin
    shifted = sequence_out >> (2 * (NUM_MOVES - 1 - int'(move_idx)));
    busy = state != IDLE;
    led_valid = state == SHOW;
    done = state == FINISH;
    led_dir = led_valid ? shifted[1:0] : 2'd0;
    led_onehot = led_valid ? 4'd1 << led_dir : 4'd0;
  end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: randomized scoreboard bench for sequence_player (follows SEQ_LFSR_EN when defined)
module tb_sequence_player;
  localparam int N = 4;
  localparam int ON = 3;
  localparam int OFF = 2;
  localparam int L = N * (ON + OFF) + 1;
  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
    logic [3:0] oh;
    logic [1:0] idx;
    logic       busy;
    logic       done;
  } exp_t;
  logic clock = 0, reset = 1, start = 0, abort = 0;
  logic [7:0] sequence_in = 0;
  logic [7:0] sequence_out;
  logic busy, led_valid, done;
  logic [1:0] led_dir, move_idx;
  logic [3:0] led_onehot;
  exp_t q[$];
  int errors = 0, checks = 0, left = 0;
  logic [7:0] mseq = 0;
  logic [15:0] mlfsr = 16'hACE1;
  sequence_player #(.NUM_MOVES(N), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .sequence_in(sequence_in),
    .sequence_out(sequence_out),
    .busy(busy),
    .led_valid(led_valid),
    .led_dir(led_dir),
    .led_onehot(led_onehot),
    .move_idx(move_idx),
    .done(done)
  );
  always #5 clock = ~clock;
  task automatic push_play(input logic [7:0] s);
    for (int i = 0; i < N; i++) begin
      int d;
      d = (int'(s) >> (2 * (N - 1 - i))) & 3;
      repeat (ON) q.push_back('{1'b1, 2'(d), 4'(1 << d), 2'(i), 1'b1, 1'b0});
      repeat (OFF) q.push_back('{1'b0, 2'd0, 4'd0, 2'(i), 1'b1, 1'b0});
    end
    q.push_back('{1'b0, 2'd0, 4'd0, 2'(N - 1), 1'b1, 1'b1});
  endtask
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      left = 0;
      q.delete();
      mseq = 0;
      mlfsr = 16'hACE1;
    end else begin
      logic [7:0] ld;
`ifdef SEQ_LFSR_EN
      ld = mlfsr[7:0];
`else
      ld = sequence_in;
`endif
      if (left == 0 && start) begin
        mseq = ld;
        push_play(ld);
        left = L;
      end else if (left > 0 && abort) begin
        left = 0;
        q.delete();
      end else if (left > 0) left--;
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end
  end
  always @(negedge clock) begin
    exp_t e, a;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    a = '{led_valid, led_dir, led_onehot, move_idx, busy, done};
    checks++;
    if (a !== e || sequence_out !== mseq) begin
      errors++;
      $display("FAIL cycle t=%0t act{v,dir,oh,idx,busy,done}=%b seq_out=%h exp=%b seq=%h", $time, a, sequence_out, e, mseq);
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  task automatic go(input logic [7:0] s);
    @(negedge clock);
    sequence_in = s;
    start = 1;
    @(negedge clock);
    start = 0;
  endtask
  initial begin
    repeat (3) @(negedge clock);
    chk("reset_state", {13'd0, busy, led_valid, led_dir, led_onehot, move_idx, done, sequence_out}, 0);
    reset = 0;
    repeat (6) @(negedge clock);
    go(8'h1B);
    repeat (24) @(negedge clock);
    go(8'h1B);
    repeat (3) @(negedge clock);
    sequence_in = 8'hFF;
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (20) @(negedge clock);
    go(8'h1B);
    repeat (7) @(negedge clock);
    abort = 1;
    @(negedge clock);
    abort = 0;
    chk("abort_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clock);
    go(8'h4E);
    repeat (24) @(negedge clock);
    go(8'h6C);
    repeat (1) @(negedge clock);
    @(posedge clock);
    #2 reset = 1;
    #1 chk("async_reset", {13'd0, busy, led_valid, led_dir, led_onehot, move_idx, done, sequence_out}, 0);
    repeat (2) @(negedge clock);
    reset = 0;
    repeat (6) @(negedge clock);
    go(8'hE4);
    repeat (22) begin
      sequence_in = 8'($urandom);
      @(negedge clock);
    end
    start = 1;
    sequence_in = 8'hD2;
    repeat (50) @(negedge clock);
    start = 0;
    repeat (500) begin
      start = $urandom_range(0, 9) == 0;
      abort = $urandom_range(0, 29) == 0;
      sequence_in = 8'($urandom);
      @(negedge clock);
    end
    start = 0;
    abort = 0;
    repeat (25) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
